// File: rtl/hilo_muldiv_if.sv
// HI/LO sequencer bus: EX-side op issue, pipeline stall/busy and the HI/LO write port.
interface hilo_muldiv_if;
  logic        flush;
  logic        start;
  logic [3:0]  op;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [31:0] hi_cur;
  logic [31:0] lo_cur;
  logic        stall_req;
  logic        busy;
  logic        we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output flush, start, op, opdata1, opdata2, hi_cur, lo_cur,
    input  stall_req, busy, we_o, hi_o, lo_o
  );

  modport slave (
    input  flush, start, op, opdata1, opdata2, hi_cur, lo_cur,
    output stall_req, busy, we_o, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle MULT/DIV/MTHI/MTLO sequencer producing a single-cycle HI/LO write.
// Define HILO_MADD_EN to accept MADD/MADDU/MSUB/MSUBU (accumulate into latched HI:LO).
module hilo_muldiv_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input logic          clk,
  input logic          rst,
  hilo_muldiv_if.slave bus
);
  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef HILO_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV_ZERO, S_DIV_ON, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         op_r;
  logic [31:0]        a_r, b_r, rem_r, hic_r, loc_r;
  logic [31:0]        last_hi, last_lo, res_hi, res_lo;
  logic [63:0]        prod_r;
  logic               neg_q, neg_r, stall, we;
  logic [32:0]        trial;

  function automatic logic is_mul(input logic [3:0] o);
    case (o)
      OP_MULT, OP_MULTU: is_mul = 1'b1;
`ifdef HILO_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul = 1'b1;
`endif
      default: is_mul = 1'b0;
    endcase
  endfunction

  function automatic logic is_div(input logic [3:0] o);
    is_div = (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] o);
    case (o)
      OP_MULT, OP_DIV: is_signed_op = 1'b1;
`ifdef HILO_MADD_EN
      OP_MADD, OP_MSUB: is_signed_op = 1'b1;
`endif
      default: is_signed_op = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic n);
    cond_neg = n ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic signed [63:0] sa, sb;
    sa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    sb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    mul64 = sa * sb;
  endfunction

  // Control state: FSM, iteration counter and the held HI/LO output values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      last_hi <= '0;
      last_lo <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == S_DIV_ON) ? cnt + 1'b1 : '0;
      if (we) begin
        last_hi <= res_hi;
        last_lo <= res_lo;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (is_mul(bus.op)) begin
            state_nxt = S_MUL;
            stall     = 1'b1;
          end else if (is_div(bus.op)) begin
            state_nxt = (bus.opdata2 == 32'd0) ? S_DIV_ZERO : S_DIV_ON;
            stall     = 1'b1;
          end else if (bus.op == OP_MTHI || bus.op == OP_MTLO) begin
            state_nxt = S_DONE;
          end
        end
      end
      S_MUL, S_DIV_ZERO: begin
        state_nxt = S_DONE;
        stall     = 1'b1;
      end
      S_DIV_ON: begin
        stall = 1'b1;
        if (cnt == CNT_W'(DIV_CYCLES - 1)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.flush) state_nxt = S_IDLE;
  end

  // Restoring divide step: a_r shifts the dividend out and the quotient in
  always_comb trial = {rem_r, a_r[31]} - {1'b0, b_r};

  // Datapath: operand capture at issue, then product / division iterations
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          op_r  <= bus.op;
          hic_r <= bus.hi_cur;
          loc_r <= bus.lo_cur;
          rem_r <= '0;
          neg_q <= (bus.op == OP_DIV) && (bus.opdata1[31] ^ bus.opdata2[31]);
          neg_r <= (bus.op == OP_DIV) && bus.opdata1[31];
          if (is_div(bus.op)) begin
            a_r <= cond_neg(bus.opdata1, (bus.op == OP_DIV) && bus.opdata1[31]);
            b_r <= cond_neg(bus.opdata2, (bus.op == OP_DIV) && bus.opdata2[31]);
          end else begin
            a_r <= bus.opdata1;
            b_r <= bus.opdata2;
          end
        end
      end
      S_MUL: prod_r <= mul64(a_r, b_r, is_signed_op(op_r));
      S_DIV_ZERO: begin
        a_r   <= '0;
        rem_r <= '0;
      end
      S_DIV_ON: begin
        if (!trial[32]) begin
          rem_r <= trial[31:0];
          a_r   <= {a_r[30:0], 1'b1};
        end else begin
          rem_r <= {rem_r[30:0], a_r[31]};
          a_r   <= {a_r[30:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  // Write-back: result selection presented during DONE
  always_comb begin
    res_hi = last_hi;
    res_lo = last_lo;
    case (op_r)
      OP_MULT, OP_MULTU: {res_hi, res_lo} = prod_r;
      OP_DIV, OP_DIVU: begin
        res_lo = cond_neg(a_r, neg_q);
        res_hi = cond_neg(rem_r, neg_r);
      end
      OP_MTHI: begin
        res_hi = a_r;
        res_lo = loc_r;
      end
      OP_MTLO: begin
        res_hi = hic_r;
        res_lo = a_r;
      end
`ifdef HILO_MADD_EN
      OP_MADD, OP_MADDU: {res_hi, res_lo} = {hic_r, loc_r} + prod_r;
      OP_MSUB, OP_MSUBU: {res_hi, res_lo} = {hic_r, loc_r} - prod_r;
`endif
      default: ;
    endcase
  end

  assign we            = (state == S_DONE) && !bus.flush;
  assign bus.we_o      = we;
  assign bus.hi_o      = we ? res_hi : last_hi;
  assign bus.lo_o      = we ? res_lo : last_lo;
  assign bus.busy      = (state != S_IDLE);
  assign bus.stall_req = stall && !rst;
endmodule
